// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   state_t        receiver FSM state encoding
//   OVERSAMPLE_DEF default number of CLK_BAUD16 ticks per bit
//   FRAME_W        data bits per frame
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int FRAME_W        = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: RX pin front end.
//   clk, rst_n  system clock, async active-low reset
//   rx_pin      raw serial line (asynchronous)
//   tick        oversampling enable pulse
//   tcnt        tick position within the current bit
//   rxs         synchronised line
//   fall        1->0 transition of rxs (one cycle)
//   maj         2-of-3 majority of the samples at positions MID-1, MID, MID+1;
//               valid on the tick where tcnt == MID
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int CW         = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_pin,
  input  logic          tick,
  input  logic [CW-1:0] tcnt,
  output logic          rxs,
  output logic          fall,
  output logic          maj
);

  localparam int MID = OVERSAMPLE / 2;

  logic       sync1;
  logic       rxs_d;
  logic [2:0] primed;
  logic       s0;
  logic       s1;

  // primed fills after reset so that the edge detector only compares real
  // pin samples; a line already low at reset release produces no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      rxs    <= 1'b1;
      rxs_d  <= 1'b1;
      primed <= 3'b000;
      s0     <= 1'b1;
      s1     <= 1'b1;
    end else begin
      sync1  <= rx_pin;
      rxs    <= sync1;
      rxs_d  <= rxs;
      primed <= {primed[1:0], 1'b1};
      // tcnt holds the number of ticks already seen in this bit, so the
      // tick at 1-based position p arrives with tcnt == p-1.
      if (tick && tcnt == CW'(MID - 2)) s0 <= rxs;
      if (tick && tcnt == CW'(MID - 1)) s1 <= rxs;
    end
  end

  assign fall = primed[2] & rxs_d & ~rxs;
  assign maj  = (s0 & s1) | (s0 & rxs) | (s1 & rxs);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with valid/ack byte handshake.
//   clk, rst_n    system clock, async active-low reset
//   clk_baud16    one-cycle enable at OVERSAMPLE x baud
//   rx_pin        serial line, idle high
//   rx_ack        consumer has taken rx_data
//   rx_data       last accepted byte
//   rx_valid      rx_data holds an unacknowledged byte
//   rx_busy       frame in progress
//   rx_frame_err  one-cycle pulse, stop bit sampled low
//   rx_overrun    sticky, byte completed while rx_valid was set
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_baud16,
  input  logic               rx_pin,
  input  logic               rx_ack,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_busy,
  output logic               rx_frame_err,
  output logic               rx_overrun
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int CW  = $clog2(OVERSAMPLE);

  state_t             state;
  logic [CW-1:0]      tcnt;
  logic [2:0]         bcnt;
  logic [FRAME_W-1:0] shreg;
  logic               rxs;
  logic               fall;
  logic               maj;
  logic               dec;
  logic               complete;
  logic [CW-1:0]      tcnt_wrap;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE), .CW(CW)) u_sampler (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_pin (rx_pin),
    .tick   (clk_baud16),
    .tcnt   (tcnt),
    .rxs    (rxs),
    .fall   (fall),
    .maj    (maj)
  );

  assign dec       = clk_baud16 && (tcnt == CW'(MID));
  assign complete  = (state == STOP) && dec && maj;
  assign tcnt_wrap = (tcnt == CW'(OVERSAMPLE - 1)) ? '0 : tcnt + 1'b1;
  assign rx_busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tcnt         <= '0;
      bcnt         <= '0;
      shreg        <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: if (fall) begin
          tcnt  <= '0;
          bcnt  <= '0;
          state <= START;
        end
        // tcnt runs straight through the start decision (it never reaches
        // the wrap point here), so every later decision sits exactly one
        // bit period after the previous one.
        START: if (clk_baud16) begin
          tcnt <= tcnt + 1'b1;
          if (dec) state <= maj ? IDLE : DATA;
        end
        DATA: if (clk_baud16) begin
          tcnt <= tcnt_wrap;
          if (dec) begin
            shreg <= {maj, shreg[FRAME_W-1:1]};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= STOP;
          end
        end
        // Leaving at the stop-bit midpoint lets an immediately following
        // start edge be caught.
        STOP: if (clk_baud16) begin
          tcnt <= tcnt_wrap;
          if (dec) begin
            if (maj) state <= IDLE;
            else begin
              rx_frame_err <= 1'b1;
              state        <= BREAK;
            end
          end
        end
        BREAK: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_ack && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      // An ack in the completion cycle frees the slot for the new byte.
      if (complete) begin
        if (!rx_valid || rx_ack) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at OVERSAMPLE = 16.
// The line is driven one value per tick slot (4 CLK per slot); slot s
// (1-based) is the value seen by the s-th tick after the start edge.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_baud16 = 1'b0;
  logic       rx_pin = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0;
  logic v152, v153, fe153;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_baud16   (clk_baud16),
    .rx_pin       (rx_pin),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_frame_err) ferr_cnt++;

  // One 8N1 frame as 200 slot values; index i is slot i+1.
  function automatic logic [199:0] mk(input logic [7:0] d, input logic stopv);
    logic [199:0] w;
    w = '1;
    for (int i = 0; i < 16; i++) w[i] = 1'b0;
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < 16; j++) w[16 + 16*b + j] = d[b];
    for (int i = 144; i < 160; i++) w[i] = stopv;
    return w;
  endfunction

  task automatic slot(input logic v, input logic ack);
    @(negedge clk); rx_pin = v;
    repeat (2) @(negedge clk);
    @(negedge clk); clk_baud16 = 1'b1; rx_ack = ack;
    @(posedge clk); #1; clk_baud16 = 1'b0; rx_ack = 1'b0;
  endtask

  task automatic play(input logic [199:0] w, input int first, input int last,
                      input int ack_slot);
    for (int s = first; s <= last; s++) begin
      slot(w[s-1], s == ack_slot);
      if (s == 152) v152 = rx_valid;
      if (s == 153) begin v153 = rx_valid; fe153 = rx_frame_err; end
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk); rx_ack = 1'b1;
    @(posedge clk); #1; rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", rx_busy); end
    n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr got %b want 0", rx_frame_err); end
    n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr got %b want 0", rx_overrun); end
    @(negedge clk); rst_n = 1'b1;
    repeat (8) slot(1'b1, 1'b0);
  endtask

  task automatic test_basic();
    play(mk(8'hA5, 1'b1), 1, 160, 0);
    n_cmp++; if (v152 !== 1'b0) begin n_bad++; $display("FAIL a5_early_valid got %b want 0", v152); end
    n_cmp++; if (v153 !== 1'b1) begin n_bad++; $display("FAIL a5_valid_at_153 got %b want 1", v153); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL a5_data got %h want a5", rx_data); end
    n_cmp++; if (fe153 !== 1'b0 || ferr_cnt != 0) begin n_bad++; $display("FAIL a5_ferr got %b/%0d want 0/0", fe153, ferr_cnt); end
    ack_pulse();
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL a5_ack_valid got %b want 0", rx_valid); end
  endtask

  task automatic test_glitch();
    logic [199:0] w;
    w = '1;
    for (int i = 0; i < 4; i++) w[i] = 1'b0;
    play(w, 1, 1, 0);
    n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_rise got %b want 1", rx_busy); end
    play(w, 2, 8, 0);
    n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_t8 got %b want 1", rx_busy); end
    play(w, 9, 9, 0);
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_t9 got %b want 0", rx_busy); end
    play(w, 10, 40, 0);
    n_cmp++; if (rx_valid !== 1'b0 || rx_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_no_byte got v%b b%b want v0 b0", rx_valid, rx_busy); end
  endtask

  task automatic test_frame_err();
    logic [199:0] w;
    int f0;
    w = mk(8'h3C, 1'b0);
    for (int i = 160; i < 176; i++) w[i] = 1'b0;
    f0 = ferr_cnt;
    play(w, 1, 176, 0);
    n_cmp++; if (fe153 !== 1'b1) begin n_bad++; $display("FAIL ferr_pulse got %b want 1", fe153); end
    n_cmp++; if (ferr_cnt - f0 != 1) begin n_bad++; $display("FAIL ferr_count got %0d want 1", ferr_cnt - f0); end
    n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin n_bad++; $display("FAIL ferr_no_byte got v%b d%h want v0 da5", rx_valid, rx_data); end
    n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL ferr_break_busy got %b want 1", rx_busy); end
    play(w, 177, 177, 0);
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL ferr_break_exit got %b want 0", rx_busy); end
    play(w, 178, 185, 0);
    play(mk(8'h5A, 1'b1), 1, 160, 0);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin n_bad++; $display("FAIL after_ferr got v%b d%h want v1 d5a", rx_valid, rx_data); end
    ack_pulse();
  endtask

  task automatic test_back_to_back();
    play(mk(8'h11, 1'b1), 1, 160, 0);
    play(mk(8'h22, 1'b1), 1, 160, 0);
    n_cmp++; if (rx_data !== 8'h11) begin n_bad++; $display("FAIL b2b_data got %h want 11", rx_data); end
    n_cmp++; if (rx_overrun !== 1'b1 || rx_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_ovr got o%b v%b want o1 v1", rx_overrun, rx_valid); end
    ack_pulse();
    n_cmp++; if (rx_overrun !== 1'b0 || rx_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_ack got o%b v%b want o0 v0", rx_overrun, rx_valid); end
    play(mk(8'h11, 1'b1), 1, 160, 0);
    play(mk(8'h22, 1'b1), 1, 160, 153);
    n_cmp++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_coinc got d%h v%b want d22 v1", rx_data, rx_valid); end
    n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_coinc_ovr got %b want 0", rx_overrun); end
    ack_pulse();
  endtask

  task automatic test_majority();
    logic [199:0] w;
    w = mk(8'hFF, 1'b1);
    w[71] = 1'b0;
    play(w, 1, 160, 0);
    n_cmp++; if (rx_data !== 8'hFF) begin n_bad++; $display("FAIL maj_one got %h want ff", rx_data); end
    ack_pulse();
    w[72] = 1'b0;
    play(w, 1, 160, 0);
    n_cmp++; if (rx_data !== 8'hF7) begin n_bad++; $display("FAIL maj_two got %h want f7", rx_data); end
  endtask

  task automatic test_reset_midframe();
    logic [199:0] w;
    w = mk(8'h81, 1'b1);
    play(w, 1, 84, 0);
    n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", rx_busy); end
    @(negedge clk); rst_n = 1'b0;
    #1;
    n_cmp++; if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_busy !== 1'b0 || rx_overrun !== 1'b0 || rx_frame_err !== 1'b0)
      begin n_bad++; $display("FAIL mid_reset got d%h v%b b%b o%b f%b want 00/0/0/0/0", rx_data, rx_valid, rx_busy, rx_overrun, rx_frame_err); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    play(w, 85, 110, 0);
    n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL mid_low_after_rst got %b want 0", rx_busy); end
    play(w, 111, 170, 0);
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_byte got %b want 0", rx_valid); end
    play(mk(8'h42, 1'b1), 1, 160, 0);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h42) begin n_bad++; $display("FAIL mid_next got v%b d%h want v1 d42", rx_valid, rx_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_majority();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
